router_out_port: RTL and testbench

ROUTER_OUT_PORT -- requirements
Module: router_out_port

---
 rtl/router_out_port.sv | 116 +++++++++++
 tb/tb_router_out_port.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_out_port.sv
// Output port of the router: drains one packet at a time from a router_fifo and
// presents it byte by byte to the destination, checking parity and flushing on a stall timeout.
module router_out_port #(
  parameter int TIMEOUT = 30
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_read_enb,
  output logic       fifo_soft_reset,
  input  logic       dst_ready,
  output logic       dst_valid,
  output logic [7:0] dst_data,
  output logic       dst_last,
  output logic       pkt_done,
  output logic       parity_err,
  output logic       busy
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, PRESENT, DONE} state_t;

  state_t          state;
  state_t          state_next;
  logic [6:0]      byte_idx;
  logic [5:0]      pay_len;
  logic [7:0]      xor_acc;
  logic [7:0]      data_reg;
  logic [CW-1:0]   stall_cnt;
  logic [6:0]      parity_idx;
  logic            is_last;
  logic            timed_out;

  // Index 7 bits wide so a 63-byte payload can still reach parity index 64.
  assign parity_idx = {1'b0, pay_len} + 7'd1;
  assign is_last    = (byte_idx == parity_idx);
  assign timed_out  = (state == PRESENT) && (stall_cnt == TIMEOUT_C);
  assign dst_data   = data_reg;

  always_ff @(posedge clock) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!fifo_empty) state_next = FETCH;
      FETCH:   if (!fifo_empty) state_next = LOAD;
      LOAD:    state_next = PRESENT;
      PRESENT: begin
        if (timed_out)      state_next = IDLE;
        else if (dst_ready) state_next = is_last ? DONE : FETCH;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    fifo_read_enb   = (state == FETCH) && !fifo_empty;
    fifo_soft_reset = timed_out;
    dst_valid       = (state == PRESENT) && !timed_out;
    dst_last        = (state == PRESENT) && !timed_out && is_last;
    pkt_done        = (state == DONE);
    parity_err      = (state == DONE) && (xor_acc != data_reg);
    busy            = (state != IDLE);
  end

  // Header byte restarts the running XOR; the parity byte itself is kept only in data_reg.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      byte_idx  <= '0;
      pay_len   <= '0;
      xor_acc   <= '0;
      data_reg  <= '0;
      stall_cnt <= '0;
    end else begin
      case (state)
        LOAD: begin
          data_reg  <= fifo_data;
          stall_cnt <= '0;
          if (byte_idx == 7'd0) begin
            pay_len <= fifo_data[7:2];
            xor_acc <= fifo_data;
          end else if (!is_last) begin
            xor_acc <= xor_acc ^ fifo_data;
          end
        end
        PRESENT: begin
          if (timed_out) begin
            byte_idx  <= '0;
            pay_len   <= '0;
            xor_acc   <= '0;
            data_reg  <= '0;
            stall_cnt <= '0;
          end else if (dst_ready) begin
            stall_cnt <= '0;
            byte_idx  <= byte_idx + 7'd1;
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
          end
        end
        DONE: begin
          byte_idx  <= '0;
          stall_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_router_out_port.sv
// Self-checking bench for router_out_port: FIFO model, fixed packet vectors,
// hand-written stall/reset/empty sequences and randomized packets against a packet-level model.
module tb_router_out_port;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data = 8'h00;
  logic       dst_ready = 1'b0;
  logic       fifo_read_enb, fifo_soft_reset, dst_valid, dst_last, pkt_done, parity_err, busy;
  logic [7:0] dst_data;

  router_out_port #(.TIMEOUT(30)) dut (
    .clock(clock), .resetn(resetn), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_read_enb(fifo_read_enb), .fifo_soft_reset(fifo_soft_reset), .dst_ready(dst_ready),
    .dst_valid(dst_valid), .dst_data(dst_data), .dst_last(dst_last), .pkt_done(pkt_done),
    .parity_err(parity_err), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]      hdr;
    logic [2:0][7:0] pay;
    logic [7:0]      parity;
    bit              exp_err;
  } vec_t;

  logic [7:0] fq[$];
  bit         hold_empty;
  logic [8:0] xfer_q[$];
  logic [8:0] exp_x[$];
  bit         done_q[$];
  bit         exp_err[$];
  int         xfer_cyc[$];
  int checks, passed, sr_count, valid_cycles, proto_err, stab_err, cycle;
  logic s_rd, s_sr, s_valid, s_last, s_done, s_err, s_busy;
  logic [7:0] s_data;
  bit prev_stalled;
  logic [7:0] prev_data;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  // One clock cycle: drive inputs, sample away from the edge, then model the FIFO read.
  task automatic applyStimulus(input logic rdy);
    dst_ready  = rdy;
    fifo_empty = hold_empty || (fq.size() == 0);
    #1;
    s_rd = fifo_read_enb; s_sr = fifo_soft_reset; s_valid = dst_valid; s_data = dst_data;
    s_last = dst_last; s_done = pkt_done; s_err = parity_err; s_busy = busy;
    if (s_rd === 1'b1 && fifo_empty) proto_err++;
    if (prev_stalled && s_valid === 1'b1 && s_data !== prev_data) stab_err++;
    prev_stalled = (s_valid === 1'b1) && !rdy;
    prev_data    = s_data;
    if (s_valid === 1'b1 && rdy && resetn) begin
      xfer_q.push_back({s_last, s_data});
      xfer_cyc.push_back(cycle);
    end
    if (s_valid === 1'b1) valid_cycles++;
    if (s_done === 1'b1) done_q.push_back(s_err);
    if (s_sr === 1'b1) sr_count++;
    @(posedge clock);
    #1;
    if (s_rd === 1'b1 && fq.size() > 0) fifo_data = fq.pop_front();
    if (s_sr === 1'b1) fq.delete();
    cycle++;
    @(negedge clock);
  endtask

  // Reference model: bytes come out in FIFO order, last flag on the final byte,
  // parity error iff XOR of all but the last byte differs from the last byte.
  task automatic addPacket(input logic [7:0] pkt[$], input bit track);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < pkt.size() - 1; i++) x ^= pkt[i];
    for (int i = 0; i < pkt.size(); i++) begin
      fq.push_back(pkt[i]);
      exp_x.push_back({(i == pkt.size() - 1), pkt[i]});
    end
    if (track) exp_err.push_back(x != pkt[pkt.size() - 1]);
  endtask

  task automatic addPacketWord(input logic [63:0] w, input int n, input bit track);
    logic [7:0] pkt[$];
    for (int j = 0; j < n; j++) pkt.push_back(w[8*(n-1-j) +: 8]);
    addPacket(pkt, track);
  endtask

  task automatic runPackets(input int n_done, input int budget, input int pct, input bit rand_empty);
    int streak = 0;
    int k = 0;
    logic rdy;
    while (done_q.size() < n_done && k < budget) begin
      hold_empty = rand_empty ? ($urandom_range(0, 4) == 0) : 1'b0;
      rdy = (streak >= 20) ? 1'b1 : ($urandom_range(0, 99) < pct);
      applyStimulus(rdy);
      if (s_valid === 1'b1) streak = rdy ? 0 : streak + 1;
      k++;
    end
    hold_empty = 1'b0;
    if (done_q.size() < n_done) checkOutput("run_budget", 32'(done_q.size()), 32'(n_done));
  endtask

  task automatic clearAll();
    xfer_q.delete(); exp_x.delete(); done_q.delete(); exp_err.delete(); xfer_cyc.delete();
  endtask

  task automatic compareStreams(input bit with_err);
    checkOutput("xfer_count", 32'(xfer_q.size()), 32'(exp_x.size()));
    for (int i = 0; i < xfer_q.size() && i < exp_x.size(); i++)
      checkOutput($sformatf("xfer_byte%0d", i), 32'(xfer_q[i]), 32'(exp_x[i]));
    if (with_err) begin
      checkOutput("done_count", 32'(done_q.size()), 32'(exp_err.size()));
      for (int i = 0; i < done_q.size() && i < exp_err.size(); i++)
        checkOutput($sformatf("parity_err%0d", i), 32'(done_q[i]), 32'(exp_err[i]));
    end
    clearAll();
  endtask

  initial begin
    vec_t vecs[5];
    logic [7:0] pkt[$];
    logic [7:0] b1, b2;
    int k, stalls;

    vecs[0] = '{8'h0D, {8'h33, 8'h22, 8'h11}, 8'h0D, 1'b0};
    vecs[1] = '{8'h0D, {8'h33, 8'h22, 8'h11}, 8'hFF, 1'b1};
    vecs[2] = '{8'h00, 24'h000000,            8'h00, 1'b0};
    vecs[3] = '{8'h06, {8'h00, 8'h00, 8'hA5}, 8'hA3, 1'b0};
    vecs[4] = '{8'h0B, {8'h00, 8'hC3, 8'h3C}, 8'hF5, 1'b1};

    @(negedge clock);
    resetn = 1'b0; hold_empty = 1'b1;
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    resetn = 1'b1;
    applyStimulus(1'b0);
    checkOutput("rst_read_enb",   32'(s_rd),    0);
    checkOutput("rst_soft_reset", 32'(s_sr),    0);
    checkOutput("rst_dst_valid",  32'(s_valid), 0);
    checkOutput("rst_dst_data",   32'(s_data),  0);
    checkOutput("rst_dst_last",   32'(s_last),  0);
    checkOutput("rst_pkt_done",   32'(s_done),  0);
    checkOutput("rst_parity_err", 32'(s_err),   0);
    checkOutput("rst_busy",       32'(s_busy),  0);
    hold_empty = 1'b0;

    $display("[TB] fixed packet vectors");
    for (int v = 0; v < 5; v++) begin
      pkt.delete();
      pkt.push_back(vecs[v].hdr);
      for (int j = 0; j < int'(vecs[v].hdr[7:2]); j++) pkt.push_back(vecs[v].pay[j]);
      pkt.push_back(vecs[v].parity);
      addPacket(pkt, 1'b0);
      runPackets(1, 200, 100, 1'b0);
      checkOutput($sformatf("tbl%0d_done_count", v), 32'(done_q.size()), 1);
      if (done_q.size() == 1)
        checkOutput($sformatf("tbl%0d_parity_err", v), 32'(done_q[0]), 32'(vecs[v].exp_err));
      for (int i = 1; i < xfer_cyc.size(); i++)
        checkOutput($sformatf("tbl%0d_byte_gap%0d", v, i), 32'(xfer_cyc[i] - xfer_cyc[i-1]), 3);
      compareStreams(1'b0);
    end

    $display("[TB] stall timeout");
    sr_count = 0; valid_cycles = 0;
    addPacketWord(64'h0D1122330D, 5, 1'b0);
    k = 0;
    while (sr_count == 0 && k < 100) begin
      applyStimulus(1'b0);
      k++;
    end
    checkOutput("timeout_valid_cycles", 32'(valid_cycles), 30);
    checkOutput("timeout_valid_on_flush", 32'(s_valid), 0);
    repeat (5) applyStimulus(1'b0);
    checkOutput("timeout_pulses", 32'(sr_count), 1);
    checkOutput("timeout_busy", 32'(s_busy), 0);
    checkOutput("timeout_no_done", 32'(done_q.size()), 0);
    checkOutput("timeout_no_xfer", 32'(xfer_q.size()), 0);
    clearAll();

    $display("[TB] ready on last stalled cycle");
    sr_count = 0; stalls = 0; k = 0;
    addPacketWord(64'h0D1122330D, 5, 1'b1);
    while (stalls < 29 && k < 100) begin
      applyStimulus(1'b0);
      if (s_valid === 1'b1) stalls++;
      k++;
    end
    runPackets(1, 200, 100, 1'b0);
    checkOutput("late_ready_no_flush", 32'(sr_count), 0);
    compareStreams(1'b1);

    $display("[TB] empty fifo mid packet");
    sr_count = 0;
    addPacketWord(64'h0000, 2, 1'b1);
    addPacketWord(64'h047773, 3, 1'b1);
    b2 = fq.pop_back();
    b1 = fq.pop_back();
    runPackets(1, 100, 100, 1'b0);
    repeat (40) applyStimulus(1'b1);
    checkOutput("wait_busy", 32'(s_busy), 1);
    checkOutput("wait_no_read", 32'(s_rd), 0);
    checkOutput("wait_no_flush", 32'(sr_count), 0);
    checkOutput("wait_xfer_count", 32'(xfer_q.size()), 3);
    fq.push_back(b1);
    fq.push_back(b2);
    runPackets(2, 100, 100, 1'b0);
    compareStreams(1'b1);

    $display("[TB] reset mid packet");
    sr_count = 0; k = 0;
    addPacketWord(64'h0D1122330D, 5, 1'b0);
    while (xfer_q.size() < 2 && k < 100) begin
      applyStimulus(1'b1);
      k++;
    end
    resetn = 1'b0;
    applyStimulus(1'b1);
    resetn = 1'b1;
    fq.delete();
    applyStimulus(1'b1);
    checkOutput("midrst_busy", 32'(s_busy), 0);
    checkOutput("midrst_data", 32'(s_data), 0);
    repeat (5) applyStimulus(1'b1);
    checkOutput("midrst_no_done", 32'(done_q.size()), 0);
    checkOutput("midrst_no_flush", 32'(sr_count), 0);
    clearAll();

    $display("[TB] randomized packets");
    sr_count = 0;
    for (int p = 0; p < 20; p++) begin
      int len;
      logic [7:0] x;
      len = $urandom_range(0, 10);
      pkt.delete();
      pkt.push_back({6'(len), 2'($urandom_range(0, 3))});
      for (int j = 0; j < len; j++) pkt.push_back(8'($urandom_range(0, 255)));
      x = 8'h00;
      foreach (pkt[j]) x ^= pkt[j];
      if ($urandom_range(0, 3) == 0) x ^= 8'($urandom_range(1, 255));
      pkt.push_back(x);
      addPacket(pkt, 1'b1);
    end
    runPackets(20, 20000, 70, 1'b1);
    checkOutput("rand_no_flush", 32'(sr_count), 0);
    compareStreams(1'b1);

    checkOutput("read_when_empty", 32'(proto_err), 0);
    checkOutput("data_stable", 32'(stab_err), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
